// File: rtl/seq_stage23_mem_fifo.sv
// rtl/seq_stage23_mem_fifo.sv - array FIFO with registered output stage, capacity DEPTH+1
module seq_stage23_mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+2)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = $clog2(DEPTH+2);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic             push;
    logic             pop;
    logic             refill;

    assign in_ready = (mem_count < CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;
    // The refilled word was written on an earlier edge, so rd_ptr never equals a same-cycle wr_ptr.
    assign refill   = (mem_count != '0) && (!out_valid || out_ready) && !flush;
    assign level    = LW'(mem_count) + LW'(out_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (refill) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (push && !refill) begin
                mem_count <= mem_count + CW'(1);
            end else if (!push && refill) begin
                mem_count <= mem_count - CW'(1);
            end
        end
    end

endmodule

// File: doc/seq_stage23_mem_fifo.md
SEQ_STAGE23_MEM_FIFO -- requirements
Module: seq_stage23_mem_fifo

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Parameter: DEPTH, 16, storage-array entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: flush  input  1  synchronous clear; discards all contents.
REQ-006 Port: in_valid  input  1  producer offers in_data.
REQ-007 Port: in_data  input  WIDTH  producer word.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: out_valid  output  1  out_data holds a valid word.
REQ-010 Port: out_data  output  WIDTH  head word, driven from a register.
REQ-011 Port: out_ready  input  1  consumer takes out_data this cycle.
REQ-012 Port: level  output  $clog2(DEPTH+2)  words held: array plus output register.

Function
REQ-013 Storage is an array mem[0:DEPTH-1] of WIDTH bits, written only at posedge, never reset.
REQ-014 The output register (out_valid, out_data) is separate from the array; total capacity is DEPTH+1.
REQ-015 Push occurs when in_valid && in_ready && !flush; it writes mem[wr_ptr] and advances wr_ptr modulo DEPTH.
REQ-016 in_ready = (mem_count < DEPTH); it is a function of registered state only and never depends on out_ready.
REQ-017 Pop occurs when out_valid && out_ready && !flush; out_valid clears unless a refill happens in the same cycle.
REQ-018 Refill occurs when mem_count > 0 && (!out_valid || out_ready) && !flush: out_data <= mem[rd_ptr], out_valid <= 1, rd_ptr advances modulo DEPTH.
REQ-019 No bypass: a word pushed into an empty block passes through the array; out_valid rises one cycle after acceptance (edge T push, edge T+1 refill).
REQ-020 Push and refill in the same cycle: mem_count is unchanged; ordering is preserved; a write and a read of the same address cannot both occur because the word being refilled was written in an earlier cycle.
REQ-021 A slot freed by refill at a full array raises in_ready on the following cycle, not combinationally.
REQ-022 Pointers wrap from DEPTH-1 to 0 without loss or duplication.
REQ-023 mem_count ranges over 0..DEPTH; level = mem_count + out_valid, range 0..DEPTH+1.
REQ-024 out_data holds its value while out_valid && !out_ready (stable under backpressure).
REQ-025 flush has priority over push, pop and refill: next cycle wr_ptr = rd_ptr = 0, mem_count = 0, out_valid = 0, and in_data is not stored.
REQ-026 in_valid with in_ready low has no effect, and no error is signalled.
REQ-027 out_data when out_valid = 0 is don't-care and is not checked.

Reset
REQ-028 rst_n low asynchronously sets wr_ptr = 0, rd_ptr = 0, mem_count = 0, out_valid = 0 and out_data = 0, giving in_ready = 1 and level = 0.
REQ-029 Reset asserted mid-transfer discards all contents immediately; array contents are not cleared but are unreachable.
REQ-030 After rst_n deasserts, the first posedge accepts a push normally.

Verification
REQ-031 Basic order: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_valid rises one cycle after the first push; outputs are 0x11, 0x22, 0x33 in order; level returns to 0.
REQ-032 Fill: out_ready=0, push 18 words 0x00..0x11 -> 17 are accepted; in_ready drops after the array holds 16; level=17; word 0x11 is never stored; draining yields 0x00..0x10.
REQ-033 Full with simultaneous traffic: at level 17, hold in_valid=1 and out_ready=1 -> in_ready re-rises one cycle after the first pop; steady-state throughput is 1 word/cycle; no reordering across the pointer wrap.
REQ-034 Backpressure: out_valid=1 with out_data=0xA5 and out_ready=0 for 5 cycles -> out_data stays 0xA5 and level is constant.
REQ-035 Flush: level=5 with push and pop asserted in the same cycle as flush -> next cycle level=0, out_valid=0, in_ready=1; a subsequent push of 0x3C emerges first.
REQ-036 Async reset: drop rst_n between clock edges at level=9 -> out_valid=0 and level=0 before the next posedge; the bench checks this without waiting for a clock edge.
